// File: rtl/aes_io_pkg.sv
// Shared widths and receiver state encodings for the AES serial I/O blocks.
package aes_io_pkg;
   localparam int AES_BLOCK_W = 128;
   localparam int AES_CNT_W   = 7;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_RECV = 1'b1
   } rx_state_e;
endpackage

// File: rtl/sipo_shift_reg.sv
// Right-shifting capture register: new bits enter at the MSB so an LSB-first
// stream ends up correctly aligned after DATA_W shifts.
module sipo_shift_reg
   import aes_io_pkg::*;
#(
   parameter int DATA_W = AES_BLOCK_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              shift_en,
   input  logic              serial_in,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_d;

   always_comb begin
      shift_d = shift_q;
      if (clr) begin
         shift_d = '0;
      end else if (shift_en) begin
         shift_d = {serial_in, shift_q[DATA_W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q <= '0;
      end else begin
         shift_q <= shift_d;
      end
   end

   assign q = shift_q;

endmodule

// File: rtl/sipo_128bit_rx.sv
// Serial-in/parallel-out receiver for one 128-bit AES block, LSB first,
// with a single-entry output buffer behind a valid/ready handshake.
module sipo_128bit_rx
   import aes_io_pkg::*;
#(
   parameter int DATA_W = AES_BLOCK_W,
   parameter int CNT_W  = AES_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              bit_en,
   input  logic              serial_in,
   input  logic              out_ready,
   output logic [DATA_W-1:0] parallel_out,
   output logic              out_valid,
   output logic              busy,
   output logic              overrun
);

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] pout_q, pout_d;
   logic              valid_q, valid_d;
   logic              overrun_q, overrun_d;
   logic              shift_clr;
   logic              shift_en;
   logic              complete;
   logic [DATA_W-1:0] shift_q;

   sipo_shift_reg #(.DATA_W(DATA_W)) u_shift (
      .clk       (clk),
      .reset     (reset),
      .clr       (shift_clr),
      .shift_en  (shift_en),
      .serial_in (serial_in),
      .q         (shift_q)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_clr = 1'b0;
      shift_en  = 1'b0;
      complete  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (start) begin
               shift_clr = 1'b1;
               cnt_d     = '0;
               state_d   = RX_RECV;
            end
         end
         RX_RECV: begin
            // start aborts any partial frame and wins over a qualified bit
            if (start) begin
               shift_clr = 1'b1;
               cnt_d     = '0;
            end else if (bit_en) begin
               shift_en = 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  complete = 1'b1;
                  cnt_d    = '0;
                  state_d  = RX_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = RX_IDLE;
      endcase

      pout_d    = complete ? {serial_in, shift_q[DATA_W-1:1]} : pout_q;
      overrun_d = overrun_q | (complete & valid_q & ~out_ready);
      if (complete) begin
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         pout_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pout_q    <= pout_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign parallel_out = pout_q;
   assign out_valid    = valid_q;
   assign busy         = (state_q == RX_RECV);
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_128bit_rx.sv
// Scoreboard bench for sipo_128bit_rx: the stimulus pushes expected words,
// a negedge monitor pops and compares on every handshake transfer.
module tb_sipo_128bit_rx;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         bit_en = 1'b0;
   logic         serial_in = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] parallel_out;
   logic         out_valid;
   logic         busy;
   logic         overrun;

   int           asserts = 0;
   int           fails = 0;
   logic [127:0] sb[$];
   logic         pre_valid;
   logic         busy_ok;

   localparam logic [127:0] W1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] W2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
   localparam logic [127:0] WA = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] WB = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

   sipo_128bit_rx dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bit_en       (bit_en),
      .serial_in    (serial_in),
      .out_ready    (out_ready),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs are applied, then one rising edge is consumed; returns at edge+1.
   task automatic tick(input logic s, input logic en, input logic d);
      start     = s;
      bit_en    = en;
      serial_in = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [127:0] w, input bit gap, input bit rdy_last, input int nbits);
      busy_ok   = 1'b1;
      pre_valid = 1'b0;
      tick(1'b1, 1'b0, 1'b0);
      if (busy !== 1'b1) busy_ok = 1'b0;
      for (int k = 0; k < nbits; k++) begin
         if (k == 127) pre_valid = out_valid;
         if (k == 127 && rdy_last) out_ready = 1'b1;
         tick(1'b0, 1'b1, w[k]);
         if (k != 127) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (gap) begin
               tick(1'b0, 1'b0, 1'b0);
               if (busy !== 1'b1) busy_ok = 1'b0;
            end
         end
      end
      bit_en = 1'b0;
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_word", parallel_out, 128'h0);
               end else begin
                  logic [127:0] exp_w;
                  exp_w = sb.pop_front();
                  $display("rx word %h expected %h", parallel_out, exp_w);
                  chk("rx_word", parallel_out, exp_w);
               end
            end
         end
      join_none

      // reset state
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      chk("rst_pout", parallel_out, 128'h0);
      chk("rst_valid", {127'h0, out_valid}, 128'h0);
      chk("rst_busy", {127'h0, busy}, 128'h0);
      chk("rst_overrun", {127'h0, overrun}, 128'h0);
      reset = 1'b0;
      tick(1'b0, 1'b0, 1'b0);

      // 1 loopback, continuous bit_en
      out_ready = 1'b1;
      sb.push_back(W1);
      send_frame(W1, 1'b0, 1'b0, 128);
      chk("t1_valid_before_last", {127'h0, pre_valid}, 128'h0);
      chk("t1_valid_latency", {127'h0, out_valid}, 128'h1);
      chk("t1_busy_done", {127'h0, busy}, 128'h0);
      chk("t1_busy_frame", {127'h0, busy_ok}, 128'h1);
      tick(1'b0, 1'b0, 1'b0);
      chk("t1_valid_drop", {127'h0, out_valid}, 128'h0);

      // 2 gapped bit_en
      sb.push_back(W1);
      send_frame(W1, 1'b1, 1'b0, 128);
      chk("t2_busy_frame", {127'h0, busy_ok}, 128'h1);
      chk("t2_valid", {127'h0, out_valid}, 128'h1);
      tick(1'b0, 1'b0, 1'b0);

      // 3 restart after 40 bits
      send_frame(WA, 1'b0, 1'b0, 40);
      sb.push_back(W2);
      send_frame(W2, 1'b0, 1'b0, 128);
      chk("t3_pout", parallel_out, W2);
      tick(1'b0, 1'b0, 1'b0);

      // 4a overrun: newest word wins
      out_ready = 1'b0;
      send_frame(WA, 1'b0, 1'b0, 128);
      tick(1'b0, 1'b0, 1'b0);
      chk("t4a_no_overrun_yet", {127'h0, overrun}, 128'h0);
      sb.push_back(WB);
      send_frame(WB, 1'b0, 1'b0, 128);
      chk("t4a_pout", parallel_out, WB);
      chk("t4a_valid", {127'h0, out_valid}, 128'h1);
      chk("t4a_overrun", {127'h0, overrun}, 128'h1);
      out_ready = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      chk("t4a_overrun_sticky", {127'h0, overrun}, 128'h1);

      // 5 reset mid-frame
      send_frame(WA, 1'b0, 1'b0, 70);
      reset = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      chk("t5_pout", parallel_out, 128'h0);
      chk("t5_valid", {127'h0, out_valid}, 128'h0);
      chk("t5_busy", {127'h0, busy}, 128'h0);
      chk("t5_overrun", {127'h0, overrun}, 128'h0);
      for (int k = 0; k < 130; k++) tick(1'b0, 1'b1, 1'b1);
      bit_en = 1'b0;
      chk("t5_ignored_busy", {127'h0, busy}, 128'h0);
      chk("t5_ignored_valid", {127'h0, out_valid}, 128'h0);
      sb.push_back(W1);
      send_frame(W1, 1'b0, 1'b0, 128);
      chk("t5_pout_after", parallel_out, W1);
      tick(1'b0, 1'b0, 1'b0);

      // 4b completion coincides with the transfer of the previous word
      out_ready = 1'b0;
      sb.push_back(WA);
      send_frame(WA, 1'b0, 1'b0, 128);
      tick(1'b0, 1'b0, 1'b0);
      sb.push_back(WB);
      send_frame(WB, 1'b0, 1'b1, 128);
      chk("t4b_pout", parallel_out, WB);
      chk("t4b_valid", {127'h0, out_valid}, 128'h1);
      chk("t4b_overrun", {127'h0, overrun}, 128'h0);
      tick(1'b0, 1'b0, 1'b0);
      chk("t4b_valid_drop", {127'h0, out_valid}, 128'h0);

      // 6 handshake hold
      out_ready = 1'b0;
      sb.push_back(W2);
      send_frame(W2, 1'b0, 1'b0, 128);
      for (int k = 0; k < 5; k++) begin
         tick(1'b0, 1'b0, 1'b0);
         chk("t6_hold_pout", parallel_out, W2);
         chk("t6_hold_valid", {127'h0, out_valid}, 128'h1);
      end
      out_ready = 1'b1;
      tick(1'b0, 1'b0, 1'b0);
      chk("t6_valid_drop", {127'h0, out_valid}, 128'h0);
      out_ready = 1'b0;

      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      chk("sb_drained", 128'(sb.size()), 128'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
